spi_mem_reader: RTL

SPI_MEM_READER -- requirements
Module: spi_mem_reader

---
 rtl/spi_mem_reader.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/spi_mem_reader.sv
// spi_mem_reader
//   Streams memory bytes out on a serial line, MSB first, starting at
//   address 0 and counting upward. This is the read-side counterpart of the
//   SPI memory writer. SCK edges arrive as one-clk strobes. One byte is
//   prefetched ahead so that the next byte is ready when the current byte's
//   last bit has been sampled.
//
// Ports
//   clk        : single clock; all state is updated on its rising edge
//   sync_reset : synchronous active-high reset; beats every other input
//   sel        : chip select; rising/falling are honoured only while it is high
//   rising     : SCK rising-edge strobe (the master samples so here)
//   falling    : SCK falling-edge strobe (so advances here)
//   reset_flag : transaction-start strobe; aborts and restarts from address 0
//   rd_data    : memory read data, valid one clk after the rd_en cycle
//   so         : serial data out (shreg[7])
//   rd_en      : one-clk memory read request
//   addr       : registered memory read address
//   byte_done  : one-clk strobe after the 8th honoured rising edge of a byte
//   underrun   : sticky; set when a byte load finds the prefetch buffer empty
module spi_mem_reader #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          sync_reset,
  input  logic          sel,
  input  logic          rising,
  input  logic          falling,
  input  logic          reset_flag,
  input  logic [7:0]    rd_data,
  output logic          so,
  output logic          rd_en,
  output logic [AW-1:0] addr,
  output logic          byte_done,
  output logic          underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_STREAM
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    pbuf_q, pbuf_d;
  logic          pbuf_valid_q, pbuf_valid_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic          pending_q, pending_d;
  logic          first_q, first_d;      // next capture is the first byte of a transaction
  logic          ur_clr_q, ur_clr_d;    // clear underrun one cycle after reset_flag
  logic          rd_q, rd_d;            // a read was issued last cycle
  logic          underrun_q, underrun_d;
  logic          byte_done_q, byte_done_d;
  logic [AW-1:0] addr_q, addr_d;

  logic active, rise_ok, fall_ok, wrap, do_load, do_shift, capture;

  // SCK strobes are honoured outside IDLE while selected; rising wins a tie.
  assign active   = (state_q != S_IDLE);
  assign rise_ok  = active && sel && rising;
  assign fall_ok  = active && sel && falling && !rising;
  assign wrap     = rise_ok && (bitcnt_q == 3'd7);
  assign do_load  = fall_ok && pending_q;
  assign do_shift = fall_ok && !pending_q;
  // Data returning while a reset_flag restarts the transaction is dropped.
  assign capture  = (state_q == S_WAIT) && !reset_flag;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sync_reset) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (reset_flag) begin
      state_d = S_FETCH;
    end else begin
      unique case (state_q)
        S_IDLE:   state_d = S_IDLE;
        // Hold in FETCH if a read went out last cycle (abort during FETCH),
        // so that no two reads are back to back.
        S_FETCH:  if (rd_en) state_d = S_WAIT;
        S_WAIT:   state_d = first_q ? S_LOAD : S_STREAM;
        S_LOAD:   state_d = S_FETCH;
        // A load during FETCH/WAIT rides on the read already in flight.
        S_STREAM: if (do_load) state_d = S_FETCH;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    rd_en     = (state_q == S_FETCH) && !rd_q;
    so        = shreg_q[7];
    addr      = addr_q;
    byte_done = byte_done_q;
    underrun  = underrun_q;
  end

  // ---------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------
  always_comb begin
    shreg_d      = shreg_q;
    pbuf_d       = pbuf_q;
    pbuf_valid_d = pbuf_valid_q;
    bitcnt_d     = bitcnt_q;
    pending_d    = pending_q;
    first_d      = first_q;
    ur_clr_d     = 1'b0;
    rd_d         = rd_en;
    underrun_d   = underrun_q;
    byte_done_d  = 1'b0;
    addr_d       = addr_q;

    if (reset_flag) begin
      addr_d       = '0;
      bitcnt_d     = '0;
      pbuf_valid_d = 1'b0;
      pending_d    = 1'b0;
      first_d      = 1'b1;
      ur_clr_d     = 1'b1;
    end else begin
      if (ur_clr_q) underrun_d = 1'b0;

      if (rise_ok) begin
        bitcnt_d = bitcnt_q + 3'd1;
        if (wrap) begin
          byte_done_d = 1'b1;
          pending_d   = 1'b1;
        end
      end else if (do_load) begin
        pending_d    = 1'b0;
        pbuf_valid_d = 1'b0;
        if (pbuf_valid_q) begin
          shreg_d = pbuf_q;
        end else begin
          shreg_d    = 8'h00;
          underrun_d = 1'b1;
        end
      end else if (do_shift) begin
        shreg_d = {shreg_q[6:0], 1'b0};
      end

      // Capture comes last: a byte landing in the same cycle as a load
      // refills the buffer for the next byte.
      if (capture) begin
        addr_d = addr_q + AW'(1);
        if (first_q) begin
          shreg_d = rd_data;
          first_d = 1'b0;
        end else begin
          pbuf_d       = rd_data;
          pbuf_valid_d = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      shreg_q      <= '0;
      pbuf_q       <= '0;
      pbuf_valid_q <= 1'b0;
      bitcnt_q     <= '0;
      pending_q    <= 1'b0;
      first_q      <= 1'b0;
      ur_clr_q     <= 1'b0;
      rd_q         <= 1'b0;
      underrun_q   <= 1'b0;
      byte_done_q  <= 1'b0;
      addr_q       <= '0;
    end else begin
      shreg_q      <= shreg_d;
      pbuf_q       <= pbuf_d;
      pbuf_valid_q <= pbuf_valid_d;
      bitcnt_q     <= bitcnt_d;
      pending_q    <= pending_d;
      first_q      <= first_d;
      ur_clr_q     <= ur_clr_d;
      rd_q         <= rd_d;
      underrun_q   <= underrun_d;
      byte_done_q  <= byte_done_d;
      addr_q       <= addr_d;
    end
  end

endmodule
